// File: rtl/vfpu_req_arb_if.sv
// rtl/vfpu_req_arb_if.sv - requester, VFPU issue/result and response bundle for the VFPU request arbiter
interface vfpu_req_arb_if #(
    parameter int NREQ = 4,
    parameter int DW   = 32
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*4-1:0] req_op;
    logic [NREQ*DW-1:0] req_a;
    logic [NREQ*DW-1:0] req_b;

    logic              fpu_valid;
    logic              fpu_ready;
    logic [3:0]        fpu_op;
    logic [DW-1:0]     fpu_a;
    logic [DW-1:0]     fpu_b;
    logic [1:0]        fpu_tag;

    logic              res_valid;
    logic [1:0]        res_tag;
    logic [DW-1:0]     res_data;
    logic [4:0]        res_flags;

    logic [NREQ-1:0]   rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic [4:0]        rsp_flags;
    logic [NREQ-1:0]   busy;
    logic              timeout_err;

    // arbiter side
    modport master (
        input  req_valid, req_op, req_a, req_b, fpu_ready,
               res_valid, res_tag, res_data, res_flags,
        output req_ready, fpu_valid, fpu_op, fpu_a, fpu_b, fpu_tag,
               rsp_valid, rsp_data, rsp_flags, busy, timeout_err
    );

    // requesters + VFPU side
    modport slave (
        output req_valid, req_op, req_a, req_b, fpu_ready,
               res_valid, res_tag, res_data, res_flags,
        input  req_ready, fpu_valid, fpu_op, fpu_a, fpu_b, fpu_tag,
               rsp_valid, rsp_data, rsp_flags, busy, timeout_err
    );
endinterface

// File: rtl/vfpu_req_arb.sv
// rtl/vfpu_req_arb.sv - round-robin arbiter for one VFPU issue port, optional busy timeout via VFPU_ARB_TIMEOUT_EN
module vfpu_req_arb #(
    parameter int NREQ   = 4,
    parameter int DW     = 32,
    parameter int TO_CYC = 255
) (
    input  logic           clk,
    input  logic           rst,
    vfpu_req_arb_if.master bus
);
    typedef enum logic [0:0] {IDLE, ISSUE} state_t;

    state_t            state;
    state_t            state_n;
    logic [1:0]        rr_ptr;
    logic [NREQ-1:0]   busy_q;
    logic [NREQ-1:0]   busy_n;
    logic [NREQ-1:0]   eligible;
    logic              grant_hit;
    logic [1:0]        grant_idx;
    logic [1:0]        idx;
    logic              load;
    logic              issue_done;
    logic              res_hit;
    logic [NREQ-1:0]   to_fire;

    logic [NREQ-1:0]   req_ready_q;
    logic              fpu_valid_q;
    logic [3:0]        fpu_op_q;
    logic [DW-1:0]     fpu_a_q;
    logic [DW-1:0]     fpu_b_q;
    logic [1:0]        fpu_tag_q;
    logic [NREQ-1:0]   rsp_valid_q;
    logic [DW-1:0]     rsp_data_q;
    logic [4:0]        rsp_flags_q;
    logic              timeout_err_q;

    assign bus.req_ready   = req_ready_q;
    assign bus.fpu_valid   = fpu_valid_q;
    assign bus.fpu_op      = fpu_op_q;
    assign bus.fpu_a       = fpu_a_q;
    assign bus.fpu_b       = fpu_b_q;
    assign bus.fpu_tag     = fpu_tag_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_flags   = rsp_flags_q;
    assign bus.busy        = busy_q;
    assign bus.timeout_err = timeout_err_q;

    // A result only counts if its requester really has an operation outstanding
    assign res_hit = bus.res_valid && busy_q[bus.res_tag];

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state, round-robin grant search starting one past the last issued tag
    always_comb begin
        state_n    = state;
        eligible   = bus.req_valid & ~busy_q;
        grant_hit  = 1'b0;
        grant_idx  = 2'd0;
        idx        = 2'd0;
        load       = 1'b0;
        issue_done = 1'b0;
        case (state)
            IDLE: begin
                for (int k = 1; k <= NREQ; k++) begin
                    idx = rr_ptr + 2'(k);
                    if (!grant_hit && eligible[idx]) begin
                        grant_hit = 1'b1;
                        grant_idx = idx;
                    end
                end
                if (grant_hit) begin
                    load    = 1'b1;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                if (fpu_valid_q && bus.fpu_ready) begin
                    issue_done = 1'b1;
                    state_n    = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outstanding map: results and timeouts clear, issue completion sets
    always_comb begin
        busy_n = busy_q;
        if (res_hit) begin
            busy_n[bus.res_tag] = 1'b0;
        end
        busy_n = busy_n & ~to_fire;
        if (issue_done) begin
            busy_n[fpu_tag_q] = 1'b1;
        end
    end

    // Issue register, accept pulses, response capture and outstanding map
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr      <= 2'(NREQ - 1);
            busy_q      <= '0;
            req_ready_q <= '0;
            fpu_valid_q <= 1'b0;
            fpu_op_q    <= '0;
            fpu_a_q     <= '0;
            fpu_b_q     <= '0;
            fpu_tag_q   <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_flags_q <= '0;
        end else begin
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            busy_q      <= busy_n;
            if (load) begin
                req_ready_q[grant_idx] <= 1'b1;
                fpu_valid_q            <= 1'b1;
                fpu_op_q               <= bus.req_op[int'(grant_idx)*4 +: 4];
                fpu_a_q                <= bus.req_a[int'(grant_idx)*DW +: DW];
                fpu_b_q                <= bus.req_b[int'(grant_idx)*DW +: DW];
                fpu_tag_q              <= grant_idx;
            end
            if (issue_done) begin
                fpu_valid_q <= 1'b0;
                rr_ptr      <= fpu_tag_q;
            end
            if (res_hit) begin
                rsp_valid_q[bus.res_tag] <= 1'b1;
                rsp_data_q               <= bus.res_data;
                rsp_flags_q              <= bus.res_flags;
            end
        end
    end

`ifdef VFPU_ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LIM = 8'(TO_CYC);

    logic [7:0] to_cnt [NREQ];

    // A requester times out when its busy age reaches the limit, unless its result lands that same cycle
    always_comb begin
        to_fire = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (busy_q[i] && !(res_hit && bus.res_tag == 2'(i)) &&
                (to_cnt[i] + 8'd1 == TO_LIM)) begin
                to_fire[i] = 1'b1;
            end
        end
    end

    // Per-requester age counters and sticky timeout flag
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
                to_cnt[i] <= '0;
            end
            timeout_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (issue_done && fpu_tag_q == 2'(i)) begin
                    to_cnt[i] <= '0;
                end else if (busy_q[i]) begin
                    to_cnt[i] <= to_cnt[i] + 8'd1;
                end
            end
            if (|to_fire) begin
                timeout_err_q <= 1'b1;
            end
        end
    end
`else
    logic to_unused;
    assign to_unused     = (TO_CYC > 0);
    assign to_fire       = '0;
    assign timeout_err_q = 1'b0;
`endif

endmodule

// File: tb/tb_vfpu_req_arb.sv
// tb/tb_vfpu_req_arb.sv - self-checking bench for vfpu_req_arb with a behavioural reference model
module tb_vfpu_req_arb;
    localparam int TO_CYC = 255;

    logic clk;
    logic rst;
    vfpu_req_arb_if bus ();

    vfpu_req_arb #(.NREQ(4), .DW(32), .TO_CYC(TO_CYC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit mon_en = 0;
    bit log_en = 0;
    int cyc    = 0;
    int g_idx[$];
    int g_cyc[$];

    // reference model state
    bit          m_pend;
    int          m_tag;
    int          m_last;
    logic [3:0]  m_op;
    logic [31:0] m_a, m_b;
    bit [3:0]    m_busy, m_rdy, m_rsp;
    logic [31:0] m_data;
    logic [4:0]  m_flags;
    bit          m_err;
    int          m_age[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: one outstanding issue, rotate priority after the last issued requester
    always @(posedge clk) begin : model
        bit [3:0] nbusy, nrdy, nrsp;
        int g, c, t;
        if (rst) begin
            cyc <= 0;
            m_pend <= 0; m_tag <= 0; m_last <= 3;
            m_op <= 0; m_a <= 0; m_b <= 0;
            m_busy <= 0; m_rdy <= 0; m_rsp <= 0;
            m_data <= 0; m_flags <= 0; m_err <= 0;
            for (int i = 0; i < 4; i++) m_age[i] <= 0;
        end else begin
            cyc <= cyc + 1;
            nbusy = m_busy;
            nrdy  = 0;
            nrsp  = 0;
            t = int'(bus.res_tag);
`ifdef VFPU_ARB_TIMEOUT_EN
            for (int i = 0; i < 4; i++) begin
                if (m_busy[i]) begin
                    m_age[i] <= m_age[i] + 1;
                    if (m_age[i] + 1 == TO_CYC && !(bus.res_valid && t == i)) begin
                        nbusy[i] = 0;
                        m_err <= 1;
                    end
                end
            end
`endif
            if (bus.res_valid && m_busy[t]) begin
                nrsp[t]  = 1;
                nbusy[t] = 0;
                m_data  <= bus.res_data;
                m_flags <= bus.res_flags;
            end
            if (m_pend) begin
                if (bus.fpu_ready) begin
                    nbusy[m_tag] = 1;
                    m_last      <= m_tag;
                    m_pend      <= 0;
                    m_age[m_tag] <= 0;
                end
            end else begin
                g = -1;
                for (int k = 1; k <= 4; k++) begin
                    c = (m_last + k) % 4;
                    if (g < 0 && bus.req_valid[c] && !m_busy[c]) g = c;
                end
                if (g >= 0) begin
                    m_pend <= 1;
                    m_tag  <= g;
                    m_op   <= bus.req_op[g*4 +: 4];
                    m_a    <= bus.req_a[g*32 +: 32];
                    m_b    <= bus.req_b[g*32 +: 32];
                    nrdy[g] = 1;
                end
            end
            m_busy <= nbusy;
            m_rdy  <= nrdy;
            m_rsp  <= nrsp;
        end
    end

    // Compare DUT against the model away from the active edge
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            chk("fpu_valid", 64'(bus.fpu_valid), 64'(m_pend));
            if (m_pend) begin
                chk("fpu_tag", 64'(bus.fpu_tag), 64'(m_tag));
                chk("fpu_op", 64'(bus.fpu_op), 64'(m_op));
                chk("fpu_a", 64'(bus.fpu_a), 64'(m_a));
                chk("fpu_b", 64'(bus.fpu_b), 64'(m_b));
            end
            chk("req_ready", 64'(bus.req_ready), 64'(m_rdy));
            chk("rsp_valid", 64'(bus.rsp_valid), 64'(m_rsp));
            chk("busy", 64'(bus.busy), 64'(m_busy));
            chk("rsp_data", 64'(bus.rsp_data), 64'(m_data));
            chk("rsp_flags", 64'(bus.rsp_flags), 64'(m_flags));
            chk("timeout_err", 64'(bus.timeout_err), 64'(m_err));
            if (log_en && bus.req_ready != 0) begin
                for (int i = 0; i < 4; i++) begin
                    if (bus.req_ready[i]) begin
                        g_idx.push_back(i);
                        g_cyc.push_back(cyc);
                    end
                end
            end
        end
    end

    initial begin
        int n;
        rst = 1;
        bus.req_valid = 0; bus.req_op = 0; bus.req_a = 0; bus.req_b = 0;
        bus.fpu_ready = 0;
        bus.res_valid = 0; bus.res_tag = 0; bus.res_data = 0; bus.res_flags = 0;
        repeat (3) tick();
        mon_en = 1;

        // reset values
        chk("rst_fpu_valid", 64'(bus.fpu_valid), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_fpu_tag", 64'(bus.fpu_tag), 64'd0);
        chk("rst_fpu_a", 64'(bus.fpu_a), 64'd0);
        chk("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_timeout_err", 64'(bus.timeout_err), 64'd0);

        // all four requesting: grants 0,1,2,3 on cycles 1,3,5,7 then none
        log_en = 1;
        rst = 0;
        bus.req_valid = 4'b1111;
        bus.fpu_ready = 1;
        repeat (12) tick();
        log_en = 0;
        bus.req_valid = 0;
        chk("grant_count", 64'(g_idx.size()), 64'd4);
        for (int i = 0; i < 4 && i < g_idx.size(); i++) begin
            chk("grant_idx", 64'(g_idx[i]), 64'(i));
            chk("grant_cyc", 64'(g_cyc[i]), 64'(2*i + 1));
        end
        chk("all_busy", 64'(bus.busy), 64'hF);

        // stalled issue for requester 2 holds fpu_* stable
        rst = 1; tick(); rst = 0;
        bus.req_valid = 4'b0100;
        bus.req_op    = 16'h0300;
        bus.req_a     = {32'h0, 32'h3F80_0000, 64'h0};
        bus.req_b     = {32'h0, 32'h4000_0000, 64'h0};
        bus.fpu_ready = 0;
        tick();
        bus.req_valid = 0;
        repeat (5) tick();
        chk("stall_valid", 64'(bus.fpu_valid), 64'd1);
        chk("stall_tag", 64'(bus.fpu_tag), 64'd2);
        chk("stall_op", 64'(bus.fpu_op), 64'h3);
        chk("stall_a", 64'(bus.fpu_a), 64'h3F80_0000);
        chk("stall_b", 64'(bus.fpu_b), 64'h4000_0000);
        bus.fpu_ready = 1;
        tick();
        chk("stall_done_valid", 64'(bus.fpu_valid), 64'd0);
        chk("stall_done_busy", 64'(bus.busy), 64'b0100);

        // issue of 0 completes in the same cycle tag 2's result returns
        bus.req_valid = 4'b0001;
        bus.fpu_ready = 0;
        tick();
        bus.req_valid = 0;
        bus.fpu_ready = 1;
        bus.res_valid = 1; bus.res_tag = 2; bus.res_data = 32'h1234_5678; bus.res_flags = 5'h0A;
        tick();
        bus.res_valid = 0;
        chk("both_busy", 64'(bus.busy), 64'b0001);
        chk("both_rsp", 64'(bus.rsp_valid), 64'b0100);
        chk("both_data", 64'(bus.rsp_data), 64'h1234_5678);

        // result frees requester 0 while it requests: grant only one cycle later
        bus.req_valid = 4'b0001;
        bus.res_valid = 1; bus.res_tag = 0; bus.res_data = 32'h55; bus.res_flags = 5'h01;
        tick();
        bus.res_valid = 0;
        chk("same_rsp", 64'(bus.rsp_valid), 64'b0001);
        chk("same_no_grant", 64'(bus.req_ready), 64'd0);
        tick();
        chk("same_grant_next", 64'(bus.req_ready), 64'b0001);
        bus.req_valid = 0;
        repeat (2) tick();

        // out-of-order results for tags 3 and 1
        rst = 1; tick(); rst = 0;
        bus.req_valid = 4'b1010;
        bus.fpu_ready = 1;
        repeat (5) tick();
        bus.req_valid = 0;
        chk("ooo_busy", 64'(bus.busy), 64'b1010);
        bus.res_valid = 1; bus.res_tag = 3; bus.res_data = 32'hAAAA_0001; bus.res_flags = 5'h03;
        tick();
        chk("ooo_rsp3", 64'(bus.rsp_valid), 64'b1000);
        chk("ooo_data3", 64'(bus.rsp_data), 64'hAAAA_0001);
        bus.res_tag = 1; bus.res_data = 32'hBBBB_0002; bus.res_flags = 5'h1C;
        tick();
        chk("ooo_rsp1", 64'(bus.rsp_valid), 64'b0010);
        chk("ooo_data1", 64'(bus.rsp_data), 64'hBBBB_0002);
        chk("ooo_flags1", 64'(bus.rsp_flags), 64'h1C);
        bus.res_valid = 0;
        tick();
        chk("ooo_idle_rsp", 64'(bus.rsp_valid), 64'd0);
        chk("ooo_idle_busy", 64'(bus.busy), 64'd0);
        chk("ooo_hold_data", 64'(bus.rsp_data), 64'hBBBB_0002);

        // stray result for a non-busy tag is dropped
        bus.res_valid = 1; bus.res_tag = 0; bus.res_data = 32'hDEAD_BEEF;
        tick();
        bus.res_valid = 0;
        chk("stray_rsp", 64'(bus.rsp_valid), 64'd0);
        chk("stray_busy", 64'(bus.busy), 64'd0);
        chk("stray_data", 64'(bus.rsp_data), 64'hBBBB_0002);

        // reset with requester 1 outstanding; late result dropped
        rst = 1; tick(); rst = 0;
        bus.req_valid = 4'b0010;
        repeat (3) tick();
        bus.req_valid = 0;
        chk("pre_rst_busy", 64'(bus.busy), 64'b0010);
        rst = 1; tick(); rst = 0;
        bus.res_valid = 1; bus.res_tag = 1; bus.res_data = 32'h0BAD_0001;
        tick();
        bus.res_valid = 0;
        chk("post_rst_rsp", 64'(bus.rsp_valid), 64'd0);
        chk("post_rst_busy", 64'(bus.busy), 64'd0);
        chk("post_rst_data", 64'(bus.rsp_data), 64'd0);
        chk("post_rst_fpu_valid", 64'(bus.fpu_valid), 64'd0);

        // reset in the middle of a stalled issue
        bus.req_valid = 4'b1000;
        bus.fpu_ready = 0;
        tick();
        rst = 1; tick(); rst = 0;
        bus.req_valid = 0;
        tick();
        chk("mid_issue_valid", 64'(bus.fpu_valid), 64'd0);
        chk("mid_issue_tag", 64'(bus.fpu_tag), 64'd0);
        bus.fpu_ready = 1;

`ifdef VFPU_ARB_TIMEOUT_EN
        // requester 0 never gets a result: busy drops after TO_CYC cycles
        rst = 1; tick(); rst = 0;
        bus.req_valid = 4'b0001;
        tick();
        tick();
        bus.req_valid = 0;
        n = 0;
        while (bus.busy[0] && n < 400) begin
            tick();
            n++;
        end
        chk("to_cycles", 64'(n), 64'(TO_CYC));
        chk("to_err", 64'(bus.timeout_err), 64'd1);
        bus.res_valid = 1; bus.res_tag = 0; bus.res_data = 32'h7777;
        tick();
        bus.res_valid = 0;
        chk("to_late_rsp", 64'(bus.rsp_valid), 64'd0);
        tick();
        chk("to_err_sticky", 64'(bus.timeout_err), 64'd1);
`else
        n = 0;
`endif

        mon_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
